// File: rtl/poly_frommsg_unpack.sv
// -----------------------------------------------------------------------------
// poly_frommsg_unpack
//
// Purpose:
//   Expands a 32-byte message into a KYBER_N-coefficient polynomial. Each
//   message bit, taken LSB first, becomes one coefficient:
//     bit = 1 -> (KYBER_Q+1)/2 (1665 for KYBER_Q = 3329)
//     bit = 0 -> 0
//   Bytes arrive over a valid/ready handshake. Coefficients leave over a
//   second valid/ready handshake, one per accepted transfer, in ascending
//   address order 0..KYBER_N-1.
//
// Ports:
//   iClk        in   1        sole clock; all state changes on the rising edge
//   iRst_n      in   1        synchronous active-low reset
//   iStart      in   1        begins one decode; only looked at in IDLE
//   iMsgByte    in   8        message byte, consumed LSB first
//   iMsgValid   in   1        iMsgByte is valid
//   oMsgReady   out  1        block takes iMsgByte this cycle (LOAD only)
//   oCoeff      out  o_Width  decoded coefficient
//   oCoeffAddr  out  8        coefficient index = byte_cnt*8 + bit_cnt
//   oCoeffValid out  1        oCoeff/oCoeffAddr are valid (EMIT only)
//   iCoeffReady in   1        downstream accepts the coefficient
//   oBusy       out  1        high in every state except IDLE
//   oDone       out  1        one-cycle pulse after the last coefficient
//
// All outputs are registers. The FSM and its outputs live in one clocked
// process so that every output changes together with the state it reflects.
// -----------------------------------------------------------------------------
module poly_frommsg_unpack #(
    parameter int KYBER_N = 256,
    parameter int KYBER_Q = 3329,
    parameter int o_Width = 12
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iStart,
    input  logic [7:0]         iMsgByte,
    input  logic               iMsgValid,
    output logic               oMsgReady,
    output logic [o_Width-1:0] oCoeff,
    output logic [7:0]         oCoeffAddr,
    output logic               oCoeffValid,
    input  logic               iCoeffReady,
    output logic               oBusy,
    output logic               oDone
);

    // Non-zero coefficient value; it fits o_Width, so the mask never overflows.
    localparam logic [o_Width-1:0] HALF_Q    = o_Width'((KYBER_Q + 1) / 2);
    // Index of the final message byte (31 for a 256-coefficient polynomial).
    localparam logic [4:0]         LAST_BYTE = 5'(KYBER_N / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Coefficient is a pure AND-mask of HALF_Q by the message bit.
    function automatic logic [o_Width-1:0] mask_coeff(input logic msg_bit);
        mask_coeff = HALF_Q & {o_Width{msg_bit}};
    endfunction

    state_t             state_r;
    logic [4:0]         byte_cnt_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         msg_byte_r;
    logic               msg_ready_r;
    logic               coeff_valid_r;
    logic [o_Width-1:0] coeff_r;
    logic [7:0]         coeff_addr_r;
    logic               busy_r;
    logic               done_r;

    logic               byte_accept_s;
    logic               coeff_accept_s;
    logic [2:0]         bit_next_s;
    logic [4:0]         byte_next_s;

    // Handshake qualifiers and counter increments used by the FSM.
    always_comb begin
        byte_accept_s  = msg_ready_r & iMsgValid;
        coeff_accept_s = coeff_valid_r & iCoeffReady;
        bit_next_s     = bit_cnt_r + 3'd1;
        byte_next_s    = byte_cnt_r + 5'd1;
    end

    // Decode FSM with its counters, byte register and registered outputs.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= 5'd0;
            bit_cnt_r     <= 3'd0;
            msg_byte_r    <= 8'd0;
            msg_ready_r   <= 1'b0;
            coeff_valid_r <= 1'b0;
            coeff_r       <= '0;
            coeff_addr_r  <= 8'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (iStart) begin
                        byte_cnt_r   <= 5'd0;
                        bit_cnt_r    <= 3'd0;
                        coeff_addr_r <= 8'd0;
                        msg_ready_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_LOAD;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    // Stay here with ready high until a byte is handed over;
                    // the first coefficient of that byte is valid next cycle.
                    if (byte_accept_s) begin
                        msg_byte_r    <= iMsgByte;
                        bit_cnt_r     <= 3'd0;
                        msg_ready_r   <= 1'b0;
                        coeff_valid_r <= 1'b1;
                        coeff_r       <= mask_coeff(iMsgByte[0]);
                        coeff_addr_r  <= {byte_cnt_r, 3'd0};
                        state_r       <= ST_EMIT;
                    end else begin
                        state_r       <= ST_LOAD;
                    end
                end

                ST_EMIT: begin
                    // Outputs only move on an accepted transfer, so a stalled
                    // downstream sees oCoeff/oCoeffAddr held steady.
                    if (coeff_accept_s) begin
                        if (bit_cnt_r == 3'd7) begin
                            coeff_valid_r <= 1'b0;
                            bit_cnt_r     <= 3'd0;
                            if (byte_cnt_r == LAST_BYTE) begin
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end else begin
                                byte_cnt_r   <= byte_next_s;
                                coeff_addr_r <= {byte_next_s, 3'd0};
                                msg_ready_r  <= 1'b1;
                                state_r      <= ST_LOAD;
                            end
                        end else begin
                            bit_cnt_r    <= bit_next_s;
                            coeff_r      <= mask_coeff(msg_byte_r[bit_next_s]);
                            coeff_addr_r <= {byte_cnt_r, bit_next_s};
                            state_r      <= ST_EMIT;
                        end
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end

                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    state_r       <= ST_IDLE;
                    msg_ready_r   <= 1'b0;
                    coeff_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign oMsgReady   = msg_ready_r;
    assign oCoeff      = coeff_r;
    assign oCoeffAddr  = coeff_addr_r;
    assign oCoeffValid = coeff_valid_r;
    assign oBusy       = busy_r;
    assign oDone       = done_r;

endmodule

// File: tb/tb_poly_frommsg_unpack.sv
// -----------------------------------------------------------------------------
// Directed bench for poly_frommsg_unpack. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_poly_frommsg_unpack;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iStart;
    logic [7:0]  iMsgByte;
    logic        iMsgValid;
    logic        oMsgReady;
    logic [11:0] oCoeff;
    logic [7:0]  oCoeffAddr;
    logic        oCoeffValid;
    logic        iCoeffReady;
    logic        oBusy;
    logic        oDone;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0] msg [32];

    poly_frommsg_unpack #(.KYBER_N(256), .KYBER_Q(3329), .o_Width(12)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iStart      (iStart),
        .iMsgByte    (iMsgByte),
        .iMsgValid   (iMsgValid),
        .oMsgReady   (oMsgReady),
        .oCoeff      (oCoeff),
        .oCoeffAddr  (oCoeffAddr),
        .oCoeffValid (oCoeffValid),
        .iCoeffReady (iCoeffReady),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    always #5 iClk = ~iClk;

    // Count oDone pulses as seen on rising edges.
    always @(posedge iClk) begin
        if (oDone === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(oMsgReady),   32'd0);
        chk({tag, "_valid"}, 32'(oCoeffValid), 32'd0);
        chk({tag, "_busy"},  32'(oBusy),       32'd0);
        chk({tag, "_done"},  32'(oDone),       32'd0);
    endtask

    // One full decode. Entered and left on a falling edge.
    //   gap      : cycles of iMsgValid=0 in LOAD before the first byte
    //   stall_at : address where iCoeffReady drops for 5 cycles
    //   start_at : address where iStart is pulsed mid-decode
    //   abort_at : address where iRst_n is pulsed; the task then returns
    task automatic run_msg(input int gap, input int stall_at, input int start_at, input int abort_at);
        int t;
        int a;
        logic [11:0] ecoef;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("start_ready", 32'(oMsgReady), 32'd1);
        chk("start_busy",  32'(oBusy),     32'd1);
        for (int b = 0; b < 32; b++) begin
            t = 0;
            while (oMsgReady !== 1'b1 && t < 16) begin
                @(negedge iClk);
                t++;
            end
            chk("ready_wait", 32'(oMsgReady), 32'd1);
            if (b == 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge iClk);
                    chk("gap_ready", 32'(oMsgReady),   32'd1);
                    chk("gap_valid", 32'(oCoeffValid), 32'd0);
                    chk("gap_addr",  32'(oCoeffAddr),  32'd0);
                end
            end
            iMsgByte  = msg[b];
            iMsgValid = 1'b1;
            @(negedge iClk);
            iMsgValid = 1'b0;
            chk("xfer_ready_low", 32'(oMsgReady), 32'd0);
            for (int k = 0; k < 8; k++) begin
                a     = b * 8 + k;
                ecoef = msg[b][k] ? 12'd1665 : 12'd0;
                if (a == abort_at) begin
                    iRst_n = 1'b0;
                    @(negedge iClk);
                    iRst_n = 1'b1;
                    chk_quiet("abort");
                    chk("abort_coeff", 32'(oCoeff),     32'd0);
                    chk("abort_addr",  32'(oCoeffAddr), 32'd0);
                    return;
                end
                chk("coef_valid", 32'(oCoeffValid), 32'd1);
                chk("coef_addr",  32'(oCoeffAddr),  32'(a));
                chk("coef_value", 32'(oCoeff),      32'(ecoef));
                if (a == stall_at) begin
                    iCoeffReady = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge iClk);
                        chk("stall_valid", 32'(oCoeffValid), 32'd1);
                        chk("stall_addr",  32'(oCoeffAddr),  32'(a));
                        chk("stall_value", 32'(oCoeff),      32'(ecoef));
                    end
                    iCoeffReady = 1'b1;
                end
                if (a == start_at) iStart = 1'b1;
                @(negedge iClk);
                iStart = 1'b0;
            end
        end
        chk("done_pulse", 32'(oDone),       32'd1);
        chk("done_busy",  32'(oBusy),       32'd1);
        chk("done_valid", 32'(oCoeffValid), 32'd0);
        chk("done_ready", 32'(oMsgReady),   32'd0);
        @(negedge iClk);
        chk_quiet("after_done");
    endtask

    initial begin
        iRst_n      = 1'b0;
        iStart      = 1'b0;
        iMsgByte    = 8'h00;
        iMsgValid   = 1'b0;
        iCoeffReady = 1'b1;
        repeat (2) @(negedge iClk);
        chk_quiet("reset");
        chk("reset_coeff", 32'(oCoeff),     32'd0);
        chk("reset_addr",  32'(oCoeffAddr), 32'd0);
        iRst_n = 1'b1;
        @(negedge iClk);
        chk_quiet("idle");

        // Decode 1: 0xA5 first, LOAD gap, stall at addr 3, stray iStart at 20.
        msg[0] = 8'hA5;
        for (int i = 1; i < 32; i++) msg[i] = 8'(i * 29) ^ 8'h3C;
        run_msg(4, 3, 20, -1);
        chk("done_count_1", 32'(done_cnt), 32'd1);

        // Decode 2: all-ones message, every coefficient 1665.
        for (int i = 0; i < 32; i++) msg[i] = 8'hFF;
        run_msg(0, -1, -1, -1);
        chk("done_count_2", 32'(done_cnt), 32'd2);

        // Decode 3: reset at address 100 abandons the decode.
        for (int i = 0; i < 32; i++) msg[i] = 8'(i * 53 + 7);
        run_msg(0, -1, -1, 100);
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            chk_quiet("post_abort");
        end
        chk("done_count_3", 32'(done_cnt), 32'd2);

        // Decode 4: fresh start after the abort restarts at address 0.
        run_msg(0, -1, -1, -1);
        chk("done_count_4", 32'(done_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
